// File: rtl/multi_sel_rx.sv
// multi_sel_rx: receive end of the multi_sel shift-add multiplier stream.
// Each 4-word frame carries d, 3d, 7d, 8d with input_grant marking the d word.
// The block aligns to grant, checks every word of the frame and returns d with
// a d_valid pulse, an err pulse and a locked indicator.
//
// Optional feature: define MULTI_SEL_RX_CNT_EN to add the saturating 8-bit
// err_cnt output. Without it the port and its counter are absent.
//
// state | meaning
// ------+------------------------------------------------------------------
// HUNT  | no alignment; waiting for a grant word with clean upper bits
// TRACK | aligned; phase 0..3 selects which word of the frame is expected
module multi_sel_rx #(
   parameter int DATA_W      = 8,
   parameter int LOCK_FRAMES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              input_grant,
   input  logic [DATA_W+2:0] in_data,
   output logic [DATA_W-1:0] d_out,
   output logic              d_valid,
   output logic              err,
   output logic              locked
`ifdef MULTI_SEL_RX_CNT_EN
   ,
   output logic [7:0]        err_cnt
`endif
);

   localparam int CW = $clog2(LOCK_FRAMES + 1);

   typedef enum logic {HUNT, TRACK} state_t;

   state_t            state;
   logic [1:0]        phase;
   logic [DATA_W-1:0] cand;
   logic [CW-1:0]     good_cnt;

   logic [DATA_W+2:0] e1, e2, e3, exp_word;
   logic              upper_ok;
   logic              word_ok;
   logic              err_now;
   logic [CW-1:0]     good_nxt;

   // Expected multiples of the captured operand, built by shift-add at full width
   assign e1 = {2'b00, cand, 1'b0} + {3'b000, cand};
   assign e2 = {cand, 3'b000} - {3'b000, cand};
   assign e3 = {cand, 3'b000};

   assign upper_ok = (in_data[DATA_W+2:DATA_W] == 3'b000);
   assign good_nxt = (good_cnt == CW'(LOCK_FRAMES)) ? good_cnt : good_cnt + CW'(1);

   // Select the expected word for the current phase and decide whether this word errs
   always_comb begin
      exp_word = '0;
      case (phase)
         2'd1:    exp_word = e1;
         2'd2:    exp_word = e2;
         2'd3:    exp_word = e3;
         default: exp_word = '0;
      endcase
      word_ok = (in_data == exp_word);
      err_now = 1'b0;
      if (input_grant) begin
         // A grant inside a frame is a framing error even when the restart word is clean
         err_now = !upper_ok || (state == TRACK && phase != 2'd0);
      end else if (state == TRACK) begin
         err_now = (phase == 2'd0) || !word_ok;
      end
   end

   // Alignment FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= HUNT;
         phase    <= 2'd0;
         cand     <= '0;
         good_cnt <= '0;
         d_out    <= '0;
         d_valid  <= 1'b0;
         err      <= 1'b0;
         locked   <= 1'b0;
      end else begin
         d_valid <= 1'b0;
         err     <= err_now;
         if (err_now) begin
            good_cnt <= '0;
            locked   <= 1'b0;
         end
         case (state)
            HUNT: begin
               if (input_grant) begin
                  cand <= in_data[DATA_W-1:0];
                  if (upper_ok) begin
                     state <= TRACK;
                     phase <= 2'd1;
                  end
               end
            end
            TRACK: begin
               if (input_grant) begin
                  // Restart the frame on this word, as a HUNT capture would
                  cand <= in_data[DATA_W-1:0];
                  if (upper_ok) begin
                     phase <= 2'd1;
                  end else begin
                     state <= HUNT;
                     phase <= 2'd0;
                  end
               end else if (phase == 2'd0 || !word_ok) begin
                  state <= HUNT;
                  phase <= 2'd0;
               end else if (phase == 2'd3) begin
                  d_out    <= cand;
                  d_valid  <= 1'b1;
                  good_cnt <= good_nxt;
                  locked   <= (good_nxt == CW'(LOCK_FRAMES));
                  phase    <= 2'd0;
               end else begin
                  phase <= phase + 2'd1;
               end
            end
            default: begin
               state <= HUNT;
               phase <= 2'd0;
            end
         endcase
      end
   end

`ifdef MULTI_SEL_RX_CNT_EN
   // Saturating count of err pulses, cleared only by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_cnt <= 8'h00;
      end else if (err_now && err_cnt != 8'hFF) begin
         err_cnt <= err_cnt + 8'h01;
      end
   end
`endif

endmodule
